window_scan_ctrl: RTL and testbench

// Scan controller for the Viola-Jones front end.
// - Walks the WINDOW_SIZE x WINDOW_SIZE scan window over the integral image in raster order.
// - Issues each window position to the window_std_dev datapath and collects its std-dev STD_LATENCY cycles later.
// - Rejects low-variance windows and queues the survivors, with their coordinates, for the cascade classifier.
// - Issue rate is credit-limited, so downstream backpressure never drops a result.

---
 rtl/vj_scan_pkg.sv | 39 +++
 rtl/cand_fifo.sv | 64 ++++++
 rtl/window_scan_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_window_scan_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vj_scan_pkg.sv
// Shared types and geometry helpers for the Viola-Jones scan front end.
// Contents: coord_t (window coordinate), cand_t (queued candidate payload),
// scan_state_e (scan controller FSM states), and the LAST_ROW/LAST_COL
// helpers that give the last legal window origin along each axis.
package vj_scan_pkg;

    localparam int unsigned COORD_W = 16;
    localparam int unsigned STD_W   = 32;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t             row;
        coord_t             col;
        logic [STD_W-1:0]   std_dev;
    } cand_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_e;

    // Largest multiple of stride that keeps the window inside the image height.
    function automatic int unsigned LAST_ROW(input int unsigned img_height,
                                             input int unsigned win,
                                             input int unsigned stride);
        return ((img_height - win) / stride) * stride;
    endfunction

    // Largest multiple of stride that keeps the window inside the image width.
    function automatic int unsigned LAST_COL(input int unsigned img_width,
                                             input int unsigned win,
                                             input int unsigned stride);
        return ((img_width - win) / stride) * stride;
    endfunction

endpackage

// File: rtl/cand_fifo.sv
// Synchronous candidate FIFO (power-of-2 depth).
// Ports: clock/reset_n, push + push_data (write), pop (read-advance),
// head (current oldest entry), not_empty, count (occupancy 0..DEPTH).
// A push and a pop in the same cycle leave the occupancy unchanged.
module cand_fifo
    import vj_scan_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  cand_t            push_data,
    input  logic             pop,
    output cand_t            head,
    output logic             not_empty,
    output logic [CNT_W-1:0] count
);

    cand_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wr_en;
    logic             rd_en;

    assign wr_en = push && (cnt_q != CNT_W'(DEPTH));
    assign rd_en = pop && (cnt_q != '0);

    // Storage carries no reset; only occupancy decides what is visible.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign not_empty = (cnt_q != '0);
    assign count     = cnt_q;

endmodule

// File: rtl/window_scan_ctrl.sv
// Scan controller for the Viola-Jones front end.
// Walks the scan window over the image in raster order, issues each origin
// to the std-dev datapath, collects the std-dev STD_LATENCY cycles later,
// drops low-variance windows and queues the rest for the classifier.
// Ports:
//   clock, reset_n                 clock / async active-low reset
//   start                          frame start pulse (ignored while busy)
//   busy, done                     scan in progress / end-of-frame pulse
//   win_issue, win_row, win_col    window origin to the datapath
//   std_dev_in                     datapath result, STD_LATENCY after issue
//   cand_valid/ready/row/col/std_dev  candidate stream (valid/ready)
//   rejected_cnt                   saturating count of rejected windows
module window_scan_ctrl
    import vj_scan_pkg::*;
#(
    parameter int unsigned IMG_WIDTH   = 320,
    parameter int unsigned IMG_HEIGHT  = 240,
    parameter int unsigned WINDOW_SIZE = 24,
    parameter int unsigned STRIDE      = 1,
    parameter int unsigned STD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned MIN_STD_DEV = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        win_issue,
    output logic [15:0] win_row,
    output logic [15:0] win_col,
    input  logic [31:0] std_dev_in,
    output logic        cand_valid,
    input  logic        cand_ready,
    output logic [15:0] cand_row,
    output logic [15:0] cand_col,
    output logic [31:0] cand_std_dev,
    output logic [31:0] rejected_cnt
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    localparam coord_t            LAST_R   = coord_t'(LAST_ROW(IMG_HEIGHT, WINDOW_SIZE, STRIDE));
    localparam coord_t            LAST_C   = coord_t'(LAST_COL(IMG_WIDTH, WINDOW_SIZE, STRIDE));
    localparam coord_t            STRIDE_C = COORD_W'(STRIDE);
    localparam logic [SUM_W-1:0]  DEPTH_S  = SUM_W'(FIFO_DEPTH);
    localparam logic [31:0]       MIN_SD   = 32'(MIN_STD_DEV);

    scan_state_e            state_q, state_d;
    coord_t                 row_q, row_d;
    coord_t                 col_q, col_d;
    logic [31:0]            rej_q, rej_d;
    logic [CNT_W-1:0]       inflight_q, inflight_d;

    logic                   win_issue_q;
    coord_t                 win_row_q;
    coord_t                 win_col_q;
    logic                   busy_q;
    logic                   done_q;

    logic [STD_LATENCY-1:0] dl_vld_q;
    coord_t                 dl_row_q [STD_LATENCY];
    coord_t                 dl_col_q [STD_LATENCY];

    logic                   issue_c;
    logic                   credit_c;
    logic                   tail_vld;
    logic                   reject_c;
    logic                   push_c;
    logic                   pop_c;
    cand_t                  push_data;
    cand_t                  fifo_head;
    logic                   fifo_nempty;
    logic [CNT_W-1:0]       fifo_cnt;

    // Every issued window holds one credit until its result leaves the FIFO
    // (or is rejected), so the FIFO can always absorb every returning result.
    assign credit_c = ({1'b0, inflight_q} + {1'b0, fifo_cnt}) < DEPTH_S;

    // Result return at the tail of the delay line.
    assign tail_vld  = dl_vld_q[STD_LATENCY-1];
    assign reject_c  = tail_vld && (std_dev_in < MIN_SD);
    assign push_c    = tail_vld && !reject_c;
    assign push_data = '{row: dl_row_q[STD_LATENCY-1],
                         col: dl_col_q[STD_LATENCY-1],
                         std_dev: std_dev_in};
    assign pop_c     = fifo_nempty && cand_ready;

    // Next-state, raster walk and rejection counter.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        rej_d   = rej_q;
        issue_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    row_d   = '0;
                    col_d   = '0;
                    rej_d   = '0;
                end
            end
            SCAN: begin
                if (credit_c) begin
                    issue_c = 1'b1;
                    if (col_q == LAST_C) begin
                        col_d = '0;
                        if (row_q == LAST_R) begin
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + STRIDE_C;
                        end
                    end else begin
                        col_d = col_q + STRIDE_C;
                    end
                end
            end
            DRAIN: begin
                if ((inflight_q == '0) && (fifo_cnt == '0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reject_c && (rej_q != '1)) begin
            rej_d = rej_q + 32'd1;
        end
    end

    // Outstanding results between issue and the delay-line tail.
    always_comb begin
        inflight_d = inflight_q;
        case ({issue_c, tail_vld})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // State, counters, issue outputs and the coordinate delay line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            rej_q       <= '0;
            inflight_q  <= '0;
            win_issue_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dl_vld_q    <= '0;
            for (int i = 0; i < STD_LATENCY; i++) begin
                dl_row_q[i] <= '0;
                dl_col_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rej_q       <= rej_d;
            inflight_q  <= inflight_d;
            win_issue_q <= issue_c;
            if (issue_c) begin
                win_row_q <= row_q;
                win_col_q <= col_q;
            end
            busy_q      <= (state_d == SCAN) || (state_d == DRAIN);
            done_q      <= (state_d == DONE);
            // Stage 0 follows the registered issue so the tail lines up
            // with std_dev_in exactly STD_LATENCY cycles after win_issue.
            dl_vld_q[0] <= win_issue_q;
            dl_row_q[0] <= win_row_q;
            dl_col_q[0] <= win_col_q;
            for (int i = 1; i < STD_LATENCY; i++) begin
                dl_vld_q[i] <= dl_vld_q[i-1];
                dl_row_q[i] <= dl_row_q[i-1];
                dl_col_q[i] <= dl_col_q[i-1];
            end
        end
    end

    cand_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cand_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push_c),
        .push_data (push_data),
        .pop       (pop_c),
        .head      (fifo_head),
        .not_empty (fifo_nempty),
        .count     (fifo_cnt)
    );

    assign busy         = busy_q;
    assign done         = done_q;
    assign win_issue    = win_issue_q;
    assign win_row      = win_row_q;
    assign win_col      = win_col_q;
    assign rejected_cnt = rej_q;

    // Head is masked while empty so stale storage never reaches the classifier.
    assign cand_valid   = fifo_nempty;
    assign cand_row     = fifo_nempty ? fifo_head.row     : '0;
    assign cand_col     = fifo_nempty ? fifo_head.col     : '0;
    assign cand_std_dev = fifo_nempty ? fifo_head.std_dev : '0;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Testbench for window_scan_ctrl: two instances (26x26 stride 1, 29x29 stride 2),
// a std-dev datapath stand-in keyed on issued coordinates, and a raster-order
// model of the expected issue and candidate sequences.
module tb_window_scan_ctrl;

    localparam int unsigned MIN_SD = 50;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;

    logic        a_start, a_busy, a_done, a_win_issue, a_cand_valid, a_cand_ready;
    logic [15:0] a_win_row, a_win_col, a_cand_row, a_cand_col;
    logic [31:0] a_std_dev_in, a_cand_std_dev, a_rejected_cnt;

    logic        b_start, b_busy, b_done, b_win_issue, b_cand_valid, b_cand_ready;
    logic [15:0] b_win_row, b_win_col, b_cand_row, b_cand_col;
    logic [31:0] b_std_dev_in, b_cand_std_dev, b_rejected_cnt;

    window_scan_ctrl #(
        .IMG_WIDTH(26), .IMG_HEIGHT(26), .WINDOW_SIZE(24), .STRIDE(1),
        .STD_LATENCY(2), .FIFO_DEPTH(4), .MIN_STD_DEV(MIN_SD)
    ) u_a (
        .clock(clock), .reset_n(reset_n), .start(a_start), .busy(a_busy), .done(a_done),
        .win_issue(a_win_issue), .win_row(a_win_row), .win_col(a_win_col),
        .std_dev_in(a_std_dev_in), .cand_valid(a_cand_valid), .cand_ready(a_cand_ready),
        .cand_row(a_cand_row), .cand_col(a_cand_col), .cand_std_dev(a_cand_std_dev),
        .rejected_cnt(a_rejected_cnt)
    );

    window_scan_ctrl #(
        .IMG_WIDTH(29), .IMG_HEIGHT(29), .WINDOW_SIZE(24), .STRIDE(2),
        .STD_LATENCY(2), .FIFO_DEPTH(4), .MIN_STD_DEV(MIN_SD)
    ) u_b (
        .clock(clock), .reset_n(reset_n), .start(b_start), .busy(b_busy), .done(b_done),
        .win_issue(b_win_issue), .win_row(b_win_row), .win_col(b_win_col),
        .std_dev_in(b_std_dev_in), .cand_valid(b_cand_valid), .cand_ready(b_cand_ready),
        .cand_row(b_cand_row), .cand_col(b_cand_col), .cand_std_dev(b_cand_std_dev),
        .rejected_cnt(b_rejected_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;
    int mode = 0;

    int iss_r [2][16];
    int iss_c [2][16];
    int iss_n [2] = '{0, 0};
    int iss_h [2] = '{0, 0};
    int exp_r [2][16];
    int exp_c [2][16];
    int exp_s [2][16];
    int exp_n [2] = '{0, 0};
    int exp_h [2] = '{0, 0};
    int exp_rej [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    bit active [2] = '{1'b0, 1'b0};

    task automatic check(input string name, input longint act, input longint expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Std-dev the datapath stand-in returns for a window origin.
    function automatic int sd_of(input int r, input int c);
        case (mode)
            1:       return (c == 1) ? 10 : 100;
            2:       return (c == 1) ? 49 : ((c == 2) ? 50 : 100);
            default: return 100;
        endcase
    endfunction

    // Raster-order expectation for one frame on instance d.
    task automatic build_model(input int d);
        int w, s, lst, sd;
        w   = (d == 0) ? 26 : 29;
        s   = (d == 0) ? 1 : 2;
        lst = ((w - 24) / s) * s;
        iss_n[d] = 0; iss_h[d] = 0; exp_n[d] = 0; exp_h[d] = 0; exp_rej[d] = 0;
        for (int r = 0; r <= lst; r += s) begin
            for (int c = 0; c <= lst; c += s) begin
                iss_r[d][iss_n[d]] = r;
                iss_c[d][iss_n[d]] = c;
                iss_n[d]++;
                sd = sd_of(r, c);
                if (sd >= int'(MIN_SD)) begin
                    exp_r[d][exp_n[d]] = r;
                    exp_c[d][exp_n[d]] = c;
                    exp_s[d][exp_n[d]] = sd;
                    exp_n[d]++;
                end else begin
                    exp_rej[d]++;
                end
            end
        end
    endtask

    // Datapath stand-in plus the per-cycle compare for both instances.
    bit          pv [2][3];
    int          pr [2][3];
    int          pc [2][3];
    bit          stall [2];
    bit          prev_done [2];
    logic [15:0] hold_r [2];
    logic [15:0] hold_c [2];
    logic [31:0] hold_s [2];

    always @(negedge clock) begin : cmp
        logic        iss [2];
        logic        dn [2];
        logic        bz [2];
        logic        cv [2];
        logic        cr [2];
        logic [15:0] wr [2];
        logic [15:0] wc [2];
        logic [15:0] cro [2];
        logic [15:0] cco [2];
        logic [31:0] cs [2];
        logic [31:0] rj [2];
        logic [31:0] sd_next [2];
        iss[0] = a_win_issue; dn[0] = a_done; bz[0] = a_busy; cv[0] = a_cand_valid;
        cr[0] = a_cand_ready; wr[0] = a_win_row; wc[0] = a_win_col; cro[0] = a_cand_row;
        cco[0] = a_cand_col; cs[0] = a_cand_std_dev; rj[0] = a_rejected_cnt;
        iss[1] = b_win_issue; dn[1] = b_done; bz[1] = b_busy; cv[1] = b_cand_valid;
        cr[1] = b_cand_ready; wr[1] = b_win_row; wc[1] = b_win_col; cro[1] = b_cand_row;
        cco[1] = b_cand_col; cs[1] = b_cand_std_dev; rj[1] = b_rejected_cnt;
        for (int d = 0; d < 2; d++) begin
            sd_next[d] = 32'd0;
            if (!reset_n) begin
                for (int k = 0; k < 3; k++) pv[d][k] = 1'b0;
                stall[d] = 1'b0;
                prev_done[d] = 1'b0;
            end else begin
                for (int k = 2; k > 0; k--) begin
                    pv[d][k] = pv[d][k-1]; pr[d][k] = pr[d][k-1]; pc[d][k] = pc[d][k-1];
                end
                pv[d][0] = iss[d]; pr[d][0] = int'(wr[d]); pc[d][0] = int'(wc[d]);
                if (pv[d][2]) sd_next[d] = 32'(sd_of(pr[d][2], pc[d][2]));

                if (iss[d]) begin
                    if (iss_h[d] >= iss_n[d]) begin
                        check("unexpected_issue", 1, 0);
                    end else begin
                        check("issue_row", wr[d], iss_r[d][iss_h[d]]);
                        check("issue_col", wc[d], iss_c[d][iss_h[d]]);
                        iss_h[d]++;
                    end
                end

                if (stall[d]) begin
                    check("hold_valid", cv[d], 1);
                    check("hold_row", cro[d], hold_r[d]);
                    check("hold_col", cco[d], hold_c[d]);
                    check("hold_sd", cs[d], hold_s[d]);
                end
                stall[d] = cv[d] && !cr[d];
                hold_r[d] = cro[d]; hold_c[d] = cco[d]; hold_s[d] = cs[d];

                if (cv[d] && cr[d]) begin
                    if (exp_h[d] >= exp_n[d]) begin
                        check("unexpected_cand", 1, 0);
                    end else begin
                        check("cand_row", cro[d], exp_r[d][exp_h[d]]);
                        check("cand_col", cco[d], exp_c[d][exp_h[d]]);
                        check("cand_sd", cs[d], exp_s[d][exp_h[d]]);
                        exp_h[d]++;
                    end
                end

                if (dn[d]) check("done_width", prev_done[d], 0);
                if (active[d]) begin
                    if (dn[d]) begin
                        check("busy_at_done", bz[d], 0);
                        check("issued_all", iss_h[d], iss_n[d]);
                        check("delivered_all", exp_h[d], exp_n[d]);
                        check("rejected_at_done", rj[d], exp_rej[d]);
                        check("empty_at_done", cv[d], 0);
                        done_cnt[d]++;
                        active[d] = 1'b0;
                    end else begin
                        check("busy_in_frame", bz[d], 1);
                    end
                end else begin
                    check("done_idle", dn[d], 0);
                    check("busy_idle", bz[d], 0);
                end
                prev_done[d] = dn[d];
            end
        end
        a_std_dev_in = sd_next[0];
        b_std_dev_in = sd_next[1];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame(input int d);
        tick();
        if (d == 0) a_start = 1'b1; else b_start = 1'b1;
        tick();
        if (d == 0) a_start = 1'b0; else b_start = 1'b0;
        active[d] = 1'b1;
    endtask

    task automatic wait_done(input int d, input int base);
        int k;
        k = 0;
        while (done_cnt[d] == base && k < 3000) begin
            tick();
            k++;
        end
        check("done_reached", done_cnt[d], base + 1);
    endtask

    task automatic wait_issues(input int d, input int n);
        int k;
        k = 0;
        while (iss_h[d] < n && k < 500) begin
            tick();
            k++;
        end
        check("issues_reached", iss_h[d], n);
    endtask

    task automatic run_frame(input int d);
        int base;
        base = done_cnt[d];
        start_frame(d);
        wait_done(d, base);
        repeat (8) tick();
        check("one_done_per_start", done_cnt[d], base + 1);
    endtask

    initial begin
        int base;
        reset_n = 1'b0;
        a_start = 1'b0; b_start = 1'b0;
        a_cand_ready = 1'b1; b_cand_ready = 1'b1;
        repeat (3) tick();
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_issue", a_win_issue, 0);
        check("rst_cand_valid", a_cand_valid, 0);
        check("rst_rejected", a_rejected_cnt, 0);
        check("rst_b_busy", b_busy, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // 1: all windows survive, free-flowing classifier
        mode = 0;
        build_model(0);
        check("model1_count", exp_n[0], 9);
        check("model1_last_row", exp_r[0][8], 2);
        check("model1_last_col", exp_c[0][8], 2);
        run_frame(0);
        check("t1_rejected", a_rejected_cnt, 0);

        // 2: column 1 below threshold
        mode = 1;
        build_model(0);
        check("model2_count", exp_n[0], 6);
        check("model2_rej", exp_rej[0], 3);
        run_frame(0);
        check("t2_rejected", a_rejected_cnt, 3);

        // 2b: threshold boundary, 49 rejected and 50 kept
        mode = 2;
        build_model(0);
        check("model2b_sd", exp_s[0][1], 50);
        check("model2b_col", exp_c[0][1], 2);
        run_frame(0);
        check("t2b_rejected", a_rejected_cnt, 3);

        // 3: classifier stalled, issue limited by credit
        mode = 0;
        build_model(0);
        a_cand_ready = 1'b0;
        base = done_cnt[0];
        start_frame(0);
        repeat (20) tick();
        check("t3_issue_count", iss_h[0], 4);
        check("t3_head_valid", a_cand_valid, 1);
        check("t3_head_row", a_cand_row, 0);
        check("t3_head_col", a_cand_col, 0);
        check("t3_head_sd", a_cand_std_dev, 100);
        a_cand_ready = 1'b1;
        wait_done(0, base);
        repeat (8) tick();
        check("t3_one_done", done_cnt[0], base + 1);

        // 4: stride 2 on the 29x29 instance
        mode = 0;
        build_model(1);
        check("model4_count", exp_n[1], 9);
        check("model4_col", iss_c[1][2], 4);
        check("model4_row", iss_r[1][8], 4);
        run_frame(1);
        check("t4_rejected", b_rejected_cnt, 0);

        // 5: reset mid-scan, then a clean rescan
        mode = 1;
        build_model(0);
        start_frame(0);
        wait_issues(0, 5);
        check("t5_rej_before_reset", a_rejected_cnt, 1);
        #1;
        reset_n = 1'b0;
        active[0] = 1'b0;
        #1;
        check("t5_busy", a_busy, 0);
        check("t5_done", a_done, 0);
        check("t5_issue", a_win_issue, 0);
        check("t5_cand_valid", a_cand_valid, 0);
        check("t5_rejected", a_rejected_cnt, 0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        mode = 0;
        build_model(0);
        run_frame(0);
        check("t5_rescan_delivered", exp_h[0], 9);

        // 6: start pulses during SCAN and DRAIN are ignored
        mode = 0;
        build_model(0);
        base = done_cnt[0];
        start_frame(0);
        repeat (3) tick();
        check("t6_busy_scan", a_busy, 1);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        wait_issues(0, 9);
        a_cand_ready = 1'b0;
        check("t6_busy_drain", a_busy, 1);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (3) tick();
        a_cand_ready = 1'b1;
        wait_done(0, base);
        repeat (20) tick();
        check("t6_one_done", done_cnt[0], base + 1);
        check("t6_idle_after", a_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
